// File: rtl/sample_seq_queue.sv
// Circular stereo sample queue: stores L/R pairs and, once NUM_TAPS are held,
// replays the newest NUM_TAPS oldest-first, one per clk, framed by sequencing.
module sample_seq_queue #(
  parameter int DEPTH    = 1024,
  parameter int NUM_TAPS = 1021,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               overrun
);

  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam int JW = $clog2(NUM_TAPS + 2);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   new_ptr_q, new_ptr_d;
  logic [AW-1:0]   old_ptr_q, old_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [JW-1:0]   j_q, j_d;
  logic            sequencing_q, sequencing_d;
  logic [15:0]     lft_q, lft_d, rght_q, rght_d;
  logic            overrun_q, overrun_d;
  logic            wr_en;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_data_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Block RAM: L in the upper half, R in the lower half of each word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[new_ptr_q] <= {lft_smpl, rght_smpl};
    rd_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      new_ptr_q    <= '0;
      old_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      j_q          <= '0;
      sequencing_q <= 1'b0;
      lft_q        <= '0;
      rght_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      new_ptr_q    <= new_ptr_d;
      old_ptr_q    <= old_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      j_q          <= j_d;
      sequencing_q <= sequencing_d;
      lft_q        <= lft_d;
      rght_q       <= rght_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    new_ptr_d    = new_ptr_q;
    old_ptr_d    = old_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    j_d          = j_q;
    sequencing_d = 1'b0;
    lft_d        = '0;
    rght_d       = '0;
    overrun_d    = overrun_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrt_smpl) begin
          wr_en     = 1'b1;
          new_ptr_d = ptr_inc(new_ptr_q);
          if (cnt_q < CW'(NUM_TAPS)) cnt_d = cnt_q + CW'(1);
          else                       old_ptr_d = ptr_inc(old_ptr_q);
          if (cnt_q >= CW'(NUM_TAPS - 1)) begin
            state_d      = SEQ;
            sequencing_d = 1'b1;
            j_d          = '0;
            rd_ptr_d     = old_ptr_d;
          end
        end
      end
      SEQ: begin
        if (wrt_smpl) overrun_d = 1'b1;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        if (j_q == JW'(NUM_TAPS + 1)) begin
          state_d = IDLE;
        end else begin
          j_d          = j_q + JW'(1);
          sequencing_d = 1'b1;
        end
        // Read data lags the address by one cycle, the output register by one more.
        if (j_q != '0 && j_q <= JW'(NUM_TAPS)) begin
          lft_d  = rd_data_q[31:16];
          rght_d = rd_data_q[15:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sequencing = sequencing_q;
  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign overrun    = overrun_q;

endmodule
